hazard_stall_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage core.
- Sequences the enable/bubble controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Handles load-use hazards, taken-branch flushes, multi-cycle MDU (mult/div) occupancy of EX, and external memory wait freezes.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_stall_ctrl_pkg.sv | 6 +
 rtl/hazard_stall_ctrl.sv | 113 +++++++++++
 tb/tb_hazard_stall_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package hazard_pkg;
  typedef enum logic {RUN, MDU_WAIT} state_t;
  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MDU_LAT_DEF = 4;
endpackage

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall sequencing for the 5-stage core: load-use bubbles, branch flushes,
// multi-cycle MDU occupancy of EX, memory-wait freezes and a stall-cycle counter.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LAT     = MDU_LAT_DEF,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_wait,
  input  logic                   branch_taken,
  input  logic                   id_ex_memread,
  input  logic [4:0]             id_ex_rt,
  input  logic [4:0]             if_id_rs,
  input  logic [4:0]             if_id_rt,
  input  logic                   id_rt_used,
  input  logic                   id_is_mdu,
  output logic                   pc_we,
  output logic                   if_id_en,
  output logic                   if_id_flush,
  output logic                   id_ex_en,
  output logic                   id_ex_bubble,
  output logic                   ex_mem_bubble,
  output logic                   mdu_busy,
  output logic                   mdu_done,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  state_t     state;
  logic [3:0] mdu_cnt;
  logic       load_use;
  logic       mdu_start;

  assign load_use = id_ex_memread && (id_ex_rt != REG_ZERO) &&
                    ((id_ex_rt == if_id_rs) || (id_rt_used && (id_ex_rt == if_id_rt)));

  assign mdu_start = (state == RUN) && !mem_wait && !branch_taken && !load_use && id_is_mdu;

  // Outputs are gated by rst so they drop the moment reset is asserted.
  always_comb begin
    pc_we         = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_en      = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mdu_busy      = 1'b0;
    mdu_done      = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          if (mem_wait) begin
            pc_we = 1'b0;
          end else if (branch_taken) begin
            pc_we        = 1'b1;
            if_id_en     = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_en     = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            id_ex_en     = 1'b1;
            id_ex_bubble = 1'b1;
          end else begin
            pc_we    = 1'b1;
            if_id_en = 1'b1;
            id_ex_en = 1'b1;
          end
        end
        MDU_WAIT: begin
          mdu_busy = 1'b1;
          if (mdu_cnt != 4'd0) begin
            ex_mem_bubble = 1'b1;
          end else if (!mem_wait) begin
            mdu_done = 1'b1;
            pc_we    = 1'b1;
            if_id_en = 1'b1;
            id_ex_en = 1'b1;
          end
        end
        default: pc_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= RUN;
      mdu_cnt      <= 4'd0;
      stall_cycles <= '0;
    end else begin
      if (!pc_we && (stall_cycles != '1))
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
      case (state)
        RUN: begin
          if (mdu_start) begin
            state   <= MDU_WAIT;
            mdu_cnt <= 4'(MDU_LAT - 2);
          end
        end
        MDU_WAIT: begin
          // Countdown runs through mem_wait; only the final release waits on it.
          if (mdu_cnt != 4'd0)
            mdu_cnt <= mdu_cnt - 4'd1;
          else if (!mem_wait)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a
// cycle-indexed reference model; second instance checks counter saturation.
module tb_hazard_stall_ctrl;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  logic mem_wait, branch_taken, id_ex_memread, id_rt_used, id_is_mdu;
  logic [4:0] id_ex_rt, if_id_rs, if_id_rt;

  logic pc_we, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble, mdu_busy, mdu_done;
  logic [31:0] stall_cycles;
  logic s_pc_we, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_bubble, s_ex_mem_bubble, s_mdu_busy, s_mdu_done;
  logic [2:0] s_stall_cycles;

  int total = 0;
  int bad   = 0;

  int      cyc     = 0;
  bit      in_mdu  = 0;
  int      mdu_end = 0;
  longint  stalls  = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MDU_LAT(LAT), .STALL_CNT_W(32)) u_dut (
    .clk(clk), .rst(rst), .mem_wait(mem_wait), .branch_taken(branch_taken),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt), .if_id_rs(if_id_rs),
    .if_id_rt(if_id_rt), .id_rt_used(id_rt_used), .id_is_mdu(id_is_mdu),
    .pc_we(pc_we), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_en(id_ex_en),
    .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble), .mdu_busy(mdu_busy),
    .mdu_done(mdu_done), .stall_cycles(stall_cycles)
  );

  hazard_stall_ctrl #(.MDU_LAT(LAT), .STALL_CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .mem_wait(mem_wait), .branch_taken(branch_taken),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt), .if_id_rs(if_id_rs),
    .if_id_rt(if_id_rt), .id_rt_used(id_rt_used), .id_is_mdu(id_is_mdu),
    .pc_we(s_pc_we), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush), .id_ex_en(s_id_ex_en),
    .id_ex_bubble(s_id_ex_bubble), .ex_mem_bubble(s_ex_mem_bubble), .mdu_busy(s_mdu_busy),
    .mdu_done(s_mdu_done), .stall_cycles(s_stall_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Expected control vector {pc_we,if_id_en,if_id_flush,id_ex_en,id_ex_bubble,ex_mem_bubble,mdu_busy,mdu_done}
  function automatic logic [7:0] model_ctl();
    bit hz;
    hz = id_ex_memread && id_ex_rt != 0 &&
         (id_ex_rt == if_id_rs || (id_rt_used && id_ex_rt == if_id_rt));
    if (!rst)                 return 8'b0000_0000;
    if (in_mdu) begin
      if (cyc < mdu_end)      return 8'b0000_0110;
      if (mem_wait)           return 8'b0000_0010;
      return 8'b1101_0011;
    end
    if (mem_wait)             return 8'b0000_0000;
    if (branch_taken)         return 8'b1111_1000;
    if (hz)                   return 8'b0001_1000;
    return 8'b1101_0000;
  endfunction

  // Entered just after a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    logic [7:0] e;
    bit hz;
    if (!rst) begin in_mdu = 0; stalls = 0; end
    #1;
    e = model_ctl();
    chk("ctl",    {pc_we, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble, mdu_busy, mdu_done}, {56'd0, e});
    chk("ctl_s",  {s_pc_we, s_if_id_en, s_if_id_flush, s_id_ex_en, s_id_ex_bubble, s_ex_mem_bubble, s_mdu_busy, s_mdu_done}, {56'd0, e});
    chk("stall",  {32'd0, stall_cycles}, 64'(stalls));
    chk("stall3", {61'd0, s_stall_cycles}, 64'((stalls > 7) ? 7 : stalls));
    hz = id_ex_memread && id_ex_rt != 0 &&
         (id_ex_rt == if_id_rs || (id_rt_used && id_ex_rt == if_id_rt));
    @(posedge clk);
    if (rst) begin
      if (!e[7]) stalls++;
      if (in_mdu) begin
        if (cyc >= mdu_end && !mem_wait) in_mdu = 0;
      end else if (!mem_wait && !branch_taken && !hz && id_is_mdu) begin
        in_mdu  = 1;
        mdu_end = cyc + LAT - 1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_in();
    mem_wait = 0; branch_taken = 0; id_ex_memread = 0; id_rt_used = 0; id_is_mdu = 0;
    id_ex_rt = 0; if_id_rs = 0; if_id_rt = 0;
  endtask

  initial begin
    rst = 0;
    idle_in();
    @(negedge clk);
    step(); step();
    rst = 1;

    // load-use on rs, then a normal cycle
    id_ex_memread = 1; id_ex_rt = 5; if_id_rs = 5; step();
    idle_in(); step();
    // no hazard: rt is r0, and rt-only match without rt use
    id_ex_memread = 1; id_ex_rt = 0; if_id_rs = 0; step();
    id_ex_rt = 7; if_id_rt = 7; if_id_rs = 1; id_rt_used = 0; step();
    // rt match with rt used -> hazard
    id_rt_used = 1; step();
    // branch overrides load-use
    if_id_rs = 7; branch_taken = 1; step();
    idle_in();
    // MDU with no memory wait
    id_is_mdu = 1; step();
    id_is_mdu = 0; repeat (4) step();
    // MDU with mem_wait spanning the final count
    id_is_mdu = 1; step();
    id_is_mdu = 0; step();
    mem_wait = 1; step(); step();
    mem_wait = 0; step(); step();
    // asynchronous reset during the second MDU_WAIT cycle
    id_is_mdu = 1; step();
    id_is_mdu = 0; step();
    rst = 0; step();
    rst = 1; step();
    // saturation of the narrow counter
    mem_wait = 1; repeat (9) step();
    mem_wait = 0; step();

    for (int i = 0; i < 2000; i++) begin
      rst           = ($urandom_range(199) != 0);
      mem_wait      = ($urandom_range(4) == 0);
      branch_taken  = ($urandom_range(6) == 0);
      id_ex_memread = $urandom_range(1);
      id_rt_used    = $urandom_range(1);
      id_is_mdu     = ($urandom_range(4) == 0);
      id_ex_rt      = 5'($urandom_range(3));
      if_id_rs      = 5'($urandom_range(3));
      if_id_rt      = 5'($urandom_range(3));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
